// File: rtl/fp_accum_seq.sv
// Sequential floating-point vector accumulator. The block drives an external
// adder one operation at a time and returns each vector's sum over a valid/ready handshake.
module fp_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a1,
  output logic [31:0]      add_a2,
  output logic             add_start,
  output logic             add_reset,
  input  logic [31:0]      add_result,
  input  logic             add_done,
  output logic [31:0]      sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, WAIT_IN, START, WAIT_DONE, CLR, OUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state_reg;
  logic [31:0] acc_reg;
  logic        last_reg;
  logic        xfer;

  assign xfer = in_valid & in_ready;

  // add_a2 doubles as the latched operand b; it stays put until the next element arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      last_reg  <= 1'b0;
      count     <= '0;
      add_a1    <= '0;
      add_a2    <= '0;
      add_start <= 1'b0;
      add_reset <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      add_start <= 1'b0;
      add_reset <= 1'b0;
      case (state_reg)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            acc_reg <= in_data;
            count   <= CNT_W'(1);
            busy    <= 1'b1;
            if (in_last) begin
              state_reg <= OUT;
              sum       <= in_data;
              sum_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state_reg <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (xfer) begin
            add_a1    <= acc_reg;
            add_a2    <= in_data;
            last_reg  <= in_last;
            add_start <= 1'b1;
            in_ready  <= 1'b0;
            state_reg <= START;
            if (count != CNT_MAX) count <= count + 1'b1;
          end
        end
        START: state_reg <= WAIT_DONE;
        WAIT_DONE: begin
          // A done pulse coinciding with add_start is seen while still in START, so it is dropped.
          if (add_done) begin
            acc_reg   <= add_result;
            add_reset <= 1'b1;
            state_reg <= CLR;
          end
        end
        CLR: begin
          if (last_reg) begin
            state_reg <= OUT;
            sum       <= acc_reg;
            sum_valid <= 1'b1;
          end else begin
            state_reg <= WAIT_IN;
            in_ready  <= 1'b1;
          end
        end
        OUT: begin
          if (sum_ready) begin
            state_reg <= IDLE;
            sum_valid <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: a delayed adder stand-in plus a vector-level reference model
// (left fold of the adder function over the input elements, saturating element count).
module tb_fp_accum_seq;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk;
  logic             reset;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [31:0]      add_a1;
  logic [31:0]      add_a2;
  logic             add_start;
  logic             add_reset;
  logic [31:0]      add_result;
  logic             add_done;
  logic [31:0]      sum;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] count;
  logic             busy;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a1(add_a1), .add_a2(add_a2), .add_start(add_start), .add_reset(add_reset),
    .add_result(add_result), .add_done(add_done),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // environment knobs and observations
  int delay = 2, sum_hold = 0;
  bit rand_valid = 0, noise = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [31:0] vec[$];
  int cyc = 0, pend = 0, done_cyc = 0, xfer_cyc = 0;
  int n_starts = 0, n_resets = 0, a_unstable = 0, s_unstable = 0, ready_bad = 0, idle_bad = 0;
  int sv_rises = 0, sv_len = 0, got_vectors = 0, lat_done = 0, lat_xfer = 0;
  bit wd = 0, sv_prev = 0, idle_chk = 0;
  logic [31:0] held_a1, held_a2, first_a1, first_a2, pend_res, got_sum, ref_sum;
  logic [CNT_W-1:0] got_count, ref_count;

  // Adder stand-in: exact results for the directed operands, an arbitrary scramble otherwise
  // (the accumulator must pass any bit pattern through untouched).
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FE00000 && b == 32'h40500000) return 32'h40A00000;
    if (a == 32'h40A00000 && b == 32'hBFE00000) return 32'h40500000;
    return {a[15:0], a[31:16]} ^ (b + 32'h9E3779B9);
  endfunction

  initial begin : env
    in_valid = 0; in_data = 0; in_last = 0; sum_ready = 0; add_done = 0; add_result = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (add_reset) n_resets++;
        if (wd && (add_a1 !== held_a1 || add_a2 !== held_a2)) a_unstable++;
        if ((add_start || wd || add_reset || sum_valid) && in_ready !== 1'b0) ready_bad++;
        if (idle_chk) begin
          idle_chk = 0;
          if (busy !== 1'b0 || sum_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) idle_bad++;
        end
        if (sum_valid) begin
          if (!sv_prev) begin
            sv_rises++; sv_len = 0; got_sum = sum; got_count = count;
            lat_done = cyc - done_cyc; lat_xfer = cyc - xfer_cyc;
          end else if (sum !== got_sum) s_unstable++;
          sv_len++;
        end
        sv_prev = sum_valid;
      end else begin
        wd = 0; sv_prev = 0; idle_chk = 0;
      end
      // adder model
      add_done = 0; add_result = $urandom;
      if (reset && add_start) begin
        n_starts++;
        if (n_starts == 1) begin first_a1 = add_a1; first_a2 = add_a2; end
        held_a1 = add_a1; held_a2 = add_a2; wd = 1; pend = delay;
        pend_res = fadd(add_a1, add_a2);
        if (noise) add_done = 1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin add_done = 1; add_result = pend_res; done_cyc = cyc; wd = 0; end
      end else if (noise && $urandom_range(0, 3) == 0) add_done = 1;
      // sum sink
      sum_ready = 0;
      if (reset && sum_valid && sv_len > sum_hold) begin
        sum_ready = 1; idle_chk = 1; got_vectors++;
      end
      // element source
      in_valid = 0; in_data = $urandom; in_last = 1'($urandom);
      if (reset && q_data.size() > 0 && (!rand_valid || $urandom_range(0, 1) == 1)) begin
        in_valid = 1; in_data = q_data[0]; in_last = q_last[0];
        if (in_ready) begin
          void'(q_data.pop_front()); void'(q_last.pop_front()); xfer_cyc = cyc;
        end
      end
    end
  end

  task automatic run_vector();
    int t0;
    int n;
    n = vec.size();
    n_starts = 0; n_resets = 0; a_unstable = 0; s_unstable = 0; ready_bad = 0; idle_bad = 0;
    ref_sum = vec[0];
    for (int i = 1; i < n; i++) ref_sum = fadd(ref_sum, vec[i]);
    ref_count = (n > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(n);
    for (int i = 0; i < n; i++) begin q_data.push_back(vec[i]); q_last.push_back(i == n - 1); end
    t0 = got_vectors;
    for (int c = 0; c < 3000 && got_vectors == t0; c++) begin @(posedge clk); #1; end
    if (got_vectors == t0) begin
      checks++; errors++;
      $display("FAIL vector_timeout: got no sum after 3000 cycles, want one sum");
      q_data.delete(); q_last.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    $display("vector len=%0d sum=%h count=%0d starts=%0d", n, got_sum, got_count, n_starts);
  endtask

  task automatic test_reset();
    reset = 1; #2; reset = 0; #1;
    checks++; if ({in_ready, busy, add_start, add_reset, sum_valid} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {in_ready, busy, add_start, add_reset, sum_valid}); end
    checks++; if ({sum, add_a1, add_a2} !== 96'b0) begin errors++;
      $display("FAIL reset_data: got %h want 0", {sum, add_a1, add_a2}); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    repeat (2) @(posedge clk);
    #2; reset = 1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL ready_first_edge: got ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_two_elem();
    delay = 2; sum_hold = 0; rand_valid = 0; noise = 0;
    vec = '{32'h3FE00000, 32'h40500000};
    run_vector();
    checks++; if (n_starts != 1) begin errors++; $display("FAIL two_starts: got %0d want 1", n_starts); end
    checks++; if (first_a1 !== 32'h3FE00000 || first_a2 !== 32'h40500000) begin errors++;
      $display("FAIL two_operands: got %h %h want 3fe00000 40500000", first_a1, first_a2); end
    checks++; if (got_sum !== 32'h40A00000) begin errors++; $display("FAIL two_sum: got %h want 40a00000", got_sum); end
    checks++; if (got_count !== 3'd2) begin errors++; $display("FAIL two_count: got %0d want 2", got_count); end
    checks++; if (n_resets != 1) begin errors++; $display("FAIL two_resets: got %0d want 1", n_resets); end
    checks++; if (lat_done != 2) begin errors++; $display("FAIL two_latency: got %0d want 2", lat_done); end
  endtask

  task automatic test_single();
    vec = '{32'hC0500000};
    run_vector();
    checks++; if (n_starts != 0 || n_resets != 0) begin errors++;
      $display("FAIL single_adds: got starts=%0d resets=%0d want 0 0", n_starts, n_resets); end
    checks++; if (got_sum !== 32'hC0500000) begin errors++; $display("FAIL single_sum: got %h want c0500000", got_sum); end
    checks++; if (got_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", got_count); end
    checks++; if (lat_xfer != 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat_xfer); end
  endtask

  task automatic test_three();
    vec = '{32'h3FE00000, 32'h40500000, 32'hBFE00000};
    run_vector();
    checks++; if (n_starts != 2 || n_resets != 2) begin errors++;
      $display("FAIL three_adds: got starts=%0d resets=%0d want 2 2", n_starts, n_resets); end
    checks++; if (got_sum !== 32'h40500000) begin errors++; $display("FAIL three_sum: got %h want 40500000", got_sum); end
    checks++; if (got_count !== 3'd3) begin errors++; $display("FAIL three_count: got %0d want 3", got_count); end
  endtask

  task automatic test_backpressure();
    sum_hold = 5;
    vec = '{32'h3FE00000, 32'h40500000};
    run_vector();
    checks++; if (sv_len != 6) begin errors++; $display("FAIL bp_hold_len: got %0d want 6", sv_len); end
    checks++; if (s_unstable != 0) begin errors++; $display("FAIL bp_sum_stable: got %0d changes want 0", s_unstable); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL bp_in_ready: got %0d bad cycles want 0", ready_bad); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL bp_idle_after: got %0d want 0", idle_bad); end
    checks++; if (got_sum !== 32'h40A00000) begin errors++; $display("FAIL bp_sum: got %h want 40a00000", got_sum); end
    sum_hold = 0;
  endtask

  task automatic test_slow_adder_random();
    delay = 4; rand_valid = 1; noise = 1;
    for (int v = 0; v < 10; v++) begin
      int n;
      n = $urandom_range(1, 10);
      vec.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0: vec.push_back(32'h7F800000);
          1: vec.push_back(32'h7FC00001);
          2: vec.push_back(32'h00000001);
          3: vec.push_back(32'hFF800000);
          default: vec.push_back($urandom);
        endcase
      end
      sum_hold = $urandom_range(0, 3);
      run_vector();
      checks++; if (got_sum !== ref_sum) begin errors++; $display("FAIL rnd_sum v%0d: got %h want %h", v, got_sum, ref_sum); end
      checks++; if (got_count !== ref_count) begin errors++; $display("FAIL rnd_count v%0d: got %0d want %0d", v, got_count, ref_count); end
      checks++; if (n_starts != n - 1 || n_resets != n - 1) begin errors++;
        $display("FAIL rnd_adds v%0d: got starts=%0d resets=%0d want %0d", v, n_starts, n_resets, n - 1); end
      checks++; if (a_unstable != 0 || ready_bad != 0 || s_unstable != 0) begin errors++;
        $display("FAIL rnd_stability v%0d: got a=%0d ready=%0d sum=%0d want 0", v, a_unstable, ready_bad, s_unstable); end
    end
    delay = 2; rand_valid = 0; noise = 0; sum_hold = 0;
  endtask

  task automatic test_reset_abort();
    int rises0;
    int bad;
    delay = 8; bad = 0;
    rises0 = sv_rises;
    vec = '{32'h3FE00000, 32'h40500000, 32'hBFE00000};
    for (int i = 0; i < 3; i++) begin q_data.push_back(vec[i]); q_last.push_back(i == 2); end
    for (int c = 0; c < 200 && !wd; c++) begin @(posedge clk); #1; end
    checks++; if (!wd) begin errors++; $display("FAIL abort_reach_wait: got no add_start, want one"); end
    #1; reset = 0; q_data.delete(); q_last.delete(); #1;
    checks++; if ({in_ready, busy, add_start, add_reset, sum_valid} !== 5'b0 || {sum, add_a1, add_a2} !== 96'b0
                  || count !== '0) begin errors++;
      $display("FAIL abort_outputs: got flags=%b a1=%h a2=%h sum=%h count=%0d want all 0",
               {in_ready, busy, add_start, add_reset, sum_valid}, add_a1, add_a2, sum, count); end
    repeat (2) @(posedge clk);
    #2; reset = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || sum_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || sv_rises != rises0 || pend != 0) begin errors++;
      $display("FAIL abort_late_done: got bad=%0d rises=%0d pend=%0d want 0 %0d 0", bad, sv_rises, pend, rises0); end
    delay = 2;
    vec = '{32'h3FE00000, 32'h40500000};
    run_vector();
    checks++; if (got_sum !== 32'h40A00000 || got_count !== 3'd2) begin errors++;
      $display("FAIL abort_next_vector: got %h count %0d want 40a00000 count 2", got_sum, got_count); end
  endtask

  initial begin : main
    test_reset();
    test_two_elem();
    test_single();
    test_three();
    test_backpressure();
    test_slow_adder_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got no finish within 50000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 Parameter: CNT_W, default 16, width of element counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserting (0) forces reset state immediately, release synchronous to clk.
REQ-004 in_data  in  32  IEEE-754 single-precision element.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_last  in  1  final element of current vector; qualified by in_valid.
REQ-007 in_ready  out  1  block accepts element this cycle.
REQ-008 add_a1  out  32  adder operand 1 (running sum).
REQ-009 add_a2  out  32  adder operand 2 (new element).
REQ-010 add_start  out  1  one-cycle adder start pulse.
REQ-011 add_reset  out  1  one-cycle, active-high adder clear pulse.
REQ-012 add_result  in  32  adder sum.
REQ-013 add_done  in  1  adder result valid.
REQ-014 sum  out  32  accumulated vector sum.
REQ-015 sum_valid  out  1  sum valid; held until accepted.
REQ-016 sum_ready  in  1  downstream accepts sum.
REQ-017 count  out  CNT_W  elements accepted in current vector, saturating.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, WAIT_IN, START, WAIT_DONE, CLR, OUT.
REQ-020 Transfer on an input occurs when in_valid and in_ready are both 1; in_ready SHALL be 1 only in IDLE and WAIT_IN.
REQ-021 IDLE: on transfer, acc <= in_data and count <= 1; no add_start is issued; next state is OUT if in_last, else WAIT_IN.
REQ-022 WAIT_IN: on transfer, latch in_data as operand b, latch in_last, increment count (saturating at all-ones), then go to START.
REQ-023 START: add_a1=acc, add_a2=b, add_start=1 for exactly one cycle, then go to WAIT_DONE.
REQ-024 WAIT_DONE: add_a1/add_a2 held stable and add_start=0; on add_done=1, acc <= add_result, then go to CLR.
REQ-025 CLR: add_reset=1 for exactly one cycle; next state is OUT if latched last, else WAIT_IN.
REQ-026 OUT: sum=acc and sum_valid=1; sum is held stable while sum_ready=0; on sum_ready=1, go to IDLE and clear count next cycle.
REQ-027 Latency: the first sum_valid cycle occurs 1 cycle after the add_done cycle plus 1 CLR cycle; for a single-element vector, sum_valid rises on the cycle after the transfer.
REQ-028 add_done is ignored in every state except WAIT_DONE; add_done arriving in the same cycle as add_start is not accepted.
REQ-029 The block passes add_result through unmodified (NaN, Inf and denormal values included); the block performs no arithmetic of its own.
REQ-030 Only one add operation is outstanding at any time; in_ready=0 from START through CLR.

Reset
REQ-031 With reset=0: state=IDLE; acc, b, sum, add_a1, add_a2 = 0; count=0; add_start, add_reset, sum_valid, in_ready and busy = 0.
REQ-032 in_ready SHALL rise to 1 on the first clk edge after reset is released.
REQ-033 Reset asserted in any state, including WAIT_DONE, aborts the vector with no sum_valid issued; a late add_done after reset release is ignored.

Verification
REQ-034 Stream 0x3FE00000 (1.75), then 0x40500000 (3.25, last) -> exactly one add_start with a1=0x3FE00000, a2=0x40500000; sum=0x40A00000 (5.0); count=2.
REQ-035 Single element 0xC0500000 with last -> no add_start or add_reset; sum=0xC0500000; count=1.
REQ-036 Stream 1.75, 3.25, 0xBFE00000 (-1.75, last) -> two add operations, each followed by one add_reset pulse; sum=0x40500000; count=3.
REQ-037 sum_ready held 0 for 5 cycles in OUT -> sum and sum_valid stable throughout; in_ready=0; IDLE reached the cycle after sum_ready=1.
REQ-038 Adder model delays add_done 4 cycles and in_valid toggles randomly -> add_a1/add_a2 stable in WAIT_DONE; no transfer while in_ready=0.
REQ-039 reset pulsed low during WAIT_DONE -> all outputs immediately take REQ-031 values; a following add_done is ignored; next vector sums correctly.
